// File: rtl/naneye_pkg.sv
`default_nettype none
// ============================================================================
// Module   : naneye_pkg
// Brief    : Shared types, framing constants and Manchester helper for the
//            NanEye transmit encoder.
// Revision : 1.0 - initial release
// ============================================================================
package naneye_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FSYNC = 2'd1,
        ST_WORD  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    localparam logic START_BIT   = 1'b1;
    localparam logic STOP_BIT    = 1'b0;
    localparam int   WORD_BITS   = 12;
    localparam int   WORD_HALVES = 2 * WORD_BITS;

    // '1' is high-then-low, '0' is low-then-high.
    function automatic logic manchester_half(input logic bit_val, input logic second_half);
        return bit_val ^ second_half;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/naneye_tx_baud.sv
`default_nettype none
// ============================================================================
// Module   : naneye_tx_baud
// Brief    : Half-bit tick divider; held in restart while the transmitter idles.
// Revision : 1.0 - initial release
// ============================================================================
module naneye_tx_baud #(
    parameter int C_HALF_BIT_CYC = 3
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic i_run,
    output logic o_tick
);

    localparam int c_cnt_w = (C_HALF_BIT_CYC > 1) ? $clog2(C_HALF_BIT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(C_HALF_BIT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (!i_run || (r_cnt == c_cnt_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tick marks the last cycle of a half-bit, so state advances on its edge.
    assign o_tick = i_run && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/naneye_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : naneye_tx_encoder
// Brief    : Frames pixel words as {start, payload, stop} and emits them as a
//            Manchester stream with frame-sync preamble and inter-line gaps.
// Revision : 1.0 - initial release
// ============================================================================
module naneye_tx_encoder
    import naneye_pkg::*;
#(
    parameter int C_HALF_BIT_CYC = 3,
    parameter int C_LINE_PIX     = 250,
    parameter int C_LINES        = 250,
    parameter int C_FSYNC_BITS   = 24,
    parameter int C_GAP_BITS     = 9,
    parameter int D_WIDTH        = 10
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic               FRAME_REQ,
    input  logic [D_WIDTH-1:0] PIX_DATA,
    input  logic               PIX_VALID,
    output logic               PIX_READY,
    output logic               SER_OUT,
    output logic               SER_OE,
    output logic               BUSY,
    output logic               FRAME_DONE,
    output logic               ERROR_OUT
);

    localparam int c_bit_w  = cnt_width((C_FSYNC_BITS > C_GAP_BITS) ? C_FSYNC_BITS : C_GAP_BITS);
    localparam int c_pix_w  = cnt_width(C_LINE_PIX);
    localparam int c_line_w = cnt_width(C_LINES);

    localparam logic [c_bit_w-1:0]  c_fsync_last = c_bit_w'(C_FSYNC_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_gap_last   = c_bit_w'(C_GAP_BITS - 1);
    localparam logic [c_pix_w-1:0]  c_pix_last   = c_pix_w'(C_LINE_PIX - 1);
    localparam logic [c_line_w-1:0] c_line_last  = c_line_w'(C_LINES - 1);
    localparam logic [4:0]          c_half_last  = 5'(WORD_HALVES - 1);

    tx_state_t             r_state;
    logic [4:0]            r_hb_idx;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [c_pix_w-1:0]    r_pix_cnt;
    logic [c_line_w-1:0]   r_line_cnt;
    logic [WORD_BITS-1:0]  r_shift;
    logic [D_WIDTH-1:0]    r_hold;
    logic                  r_full;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_done_evt;
    logic                  r_ser_out;
    logic                  r_ser_oe;
    logic                  r_busy;
    logic                  r_frame_done;

    logic                  w_run;
    logic                  w_tick;
    logic                  w_abort;
    logic                  w_fsync_last;
    logic                  w_word_last;
    logic                  w_gap_last;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_full_nxt;
    logic                  w_ser;
    logic [WORD_BITS-1:0]  w_word;

    assign w_run = (r_state != ST_IDLE);

    naneye_tx_baud #(
        .C_HALF_BIT_CYC(C_HALF_BIT_CYC)
    ) u_baud (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .i_run  (w_run),
        .o_tick (w_tick)
    );

    assign w_abort      = w_tick && !ENABLE;
    assign w_fsync_last = (r_state == ST_FSYNC) && r_hb_idx[0] && (r_bit_cnt == c_fsync_last);
    assign w_word_last  = (r_state == ST_WORD) && (r_hb_idx == c_half_last);
    assign w_gap_last   = (r_state == ST_GAP) && r_hb_idx[0] && (r_bit_cnt == c_gap_last);

    // Word starts: end of sync, between words of a line, end of a non-final gap.
    assign w_load = w_tick && ENABLE &&
                    (w_fsync_last ||
                     (w_word_last && (r_pix_cnt != c_pix_last)) ||
                     (w_gap_last && (r_line_cnt != c_line_last)));

    assign w_word = r_full ? {START_BIT, r_hold, STOP_BIT}
                           : {START_BIT, {D_WIDTH{1'b0}}, STOP_BIT};

    assign w_accept   = PIX_VALID && r_ready;
    assign w_full_nxt = w_abort  ? 1'b0 :
                        w_accept ? 1'b1 :
                        w_load   ? 1'b0 : r_full;

    always_comb begin
        w_ser = 1'b0;
        case (r_state)
            ST_FSYNC: w_ser = manchester_half(1'b1, r_hb_idx[0]);
            ST_WORD:  w_ser = manchester_half(r_shift[WORD_BITS-1], r_hb_idx[0]);
            default:  w_ser = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hold  <= '0;
            r_full  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_full  <= w_full_nxt;
            r_ready <= ~w_full_nxt;
            if (w_accept && !w_abort) begin
                r_hold <= PIX_DATA;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= ST_IDLE;
            r_hb_idx     <= '0;
            r_bit_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_shift      <= '0;
            r_err        <= 1'b0;
            r_done_evt   <= 1'b0;
            r_ser_out    <= 1'b0;
            r_ser_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Line outputs trail the sequencer by one cycle.
            r_ser_out    <= w_ser;
            r_ser_oe     <= w_run;
            r_busy       <= w_run;
            r_frame_done <= r_done_evt;
            r_done_evt   <= 1'b0;

            if (r_state == ST_IDLE) begin
                if (ENABLE && FRAME_REQ) begin
                    r_state <= ST_FSYNC;
                    r_err   <= 1'b0;
                end
            end else if (w_tick) begin
                if (!ENABLE) begin
                    r_state    <= ST_IDLE;
                    r_hb_idx   <= '0;
                    r_bit_cnt  <= '0;
                    r_pix_cnt  <= '0;
                    r_line_cnt <= '0;
                end else begin
                    case (r_state)
                        ST_FSYNC: begin
                            r_hb_idx <= {4'd0, ~r_hb_idx[0]};
                            if (r_hb_idx[0]) begin
                                if (r_bit_cnt == c_fsync_last) begin
                                    r_bit_cnt <= '0;
                                    r_state   <= ST_WORD;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                end
                            end
                        end
                        ST_WORD: begin
                            if (r_hb_idx == c_half_last) begin
                                r_hb_idx <= '0;
                                if (r_pix_cnt == c_pix_last) begin
                                    r_pix_cnt <= '0;
                                    r_state   <= ST_GAP;
                                end else begin
                                    r_pix_cnt <= r_pix_cnt + 1'b1;
                                end
                            end else begin
                                r_hb_idx <= r_hb_idx + 5'd1;
                                if (r_hb_idx[0]) begin
                                    r_shift <= {r_shift[WORD_BITS-2:0], 1'b0};
                                end
                            end
                        end
                        ST_GAP: begin
                            r_hb_idx <= {4'd0, ~r_hb_idx[0]};
                            if (r_hb_idx[0]) begin
                                if (r_bit_cnt == c_gap_last) begin
                                    r_bit_cnt <= '0;
                                    if (r_line_cnt == c_line_last) begin
                                        r_line_cnt <= '0;
                                        r_state    <= ST_IDLE;
                                        r_done_evt <= 1'b1;
                                    end else begin
                                        r_line_cnt <= r_line_cnt + 1'b1;
                                        r_state    <= ST_WORD;
                                    end
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                end
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase

                    if (w_load) begin
                        r_shift <= w_word;
                        if (!r_full) begin
                            r_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign PIX_READY  = r_ready;
    assign SER_OUT    = r_ser_out;
    assign SER_OE     = r_ser_oe;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;
    assign ERROR_OUT  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_naneye_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_naneye_tx_encoder
// Brief    : Directed bench for naneye_tx_encoder at half-bit lengths 2 and 1.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_naneye_tx_encoder;

    localparam int c_f  = 4;
    localparam int c_p  = 2;
    localparam int c_nl = 2;
    localparam int c_g  = 3;
    localparam int c_nh = 2 * (c_f + c_nl * (12 * c_p + c_g));

    logic       CLOCK_tb = 1'b0;
    logic       RESET_N_tb;
    logic       enable_tb     [2];
    logic       frame_req_tb  [2];
    logic       pix_valid_tb  [2];
    logic [9:0] pix_data_tb   [2];
    logic       pix_ready_tb  [2];
    logic       ser_out_tb    [2];
    logic       ser_oe_tb     [2];
    logic       busy_tb       [2];
    logic       frame_done_tb [2];
    logic       error_out_tb  [2];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cur   = 0;
    bit         feed_en = 1'b0;
    logic [9:0] feed_q [$];
    logic [9:0] frame_px [4];
    logic       exp_half [c_nh];
    logic       cap [2*c_nh];

    always #5 CLOCK_tb = ~CLOCK_tb;

    naneye_tx_encoder #(
        .C_HALF_BIT_CYC(2), .C_LINE_PIX(c_p), .C_LINES(c_nl),
        .C_FSYNC_BITS(c_f), .C_GAP_BITS(c_g), .D_WIDTH(10)
    ) dut_h2 (
        .CLOCK(CLOCK_tb), .RESET_N(RESET_N_tb), .ENABLE(enable_tb[0]),
        .FRAME_REQ(frame_req_tb[0]), .PIX_DATA(pix_data_tb[0]), .PIX_VALID(pix_valid_tb[0]),
        .PIX_READY(pix_ready_tb[0]), .SER_OUT(ser_out_tb[0]), .SER_OE(ser_oe_tb[0]),
        .BUSY(busy_tb[0]), .FRAME_DONE(frame_done_tb[0]), .ERROR_OUT(error_out_tb[0])
    );

    naneye_tx_encoder #(
        .C_HALF_BIT_CYC(1), .C_LINE_PIX(c_p), .C_LINES(c_nl),
        .C_FSYNC_BITS(c_f), .C_GAP_BITS(c_g), .D_WIDTH(10)
    ) dut_h1 (
        .CLOCK(CLOCK_tb), .RESET_N(RESET_N_tb), .ENABLE(enable_tb[1]),
        .FRAME_REQ(frame_req_tb[1]), .PIX_DATA(pix_data_tb[1]), .PIX_VALID(pix_valid_tb[1]),
        .PIX_READY(pix_ready_tb[1]), .SER_OUT(ser_out_tb[1]), .SER_OE(ser_oe_tb[1]),
        .BUSY(busy_tb[1]), .FRAME_DONE(frame_done_tb[1]), .ERROR_OUT(error_out_tb[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs(input int d);
        return {ser_out_tb[d], ser_oe_tb[d], pix_ready_tb[d],
                busy_tb[d], frame_done_tb[d], error_out_tb[d]};
    endfunction

    // One clock; handshake seen at the edge, then the pixel source updates.
    task automatic step();
        logic acc;
        @(posedge CLOCK_tb);
        acc = pix_valid_tb[cur] & pix_ready_tb[cur];
        #1;
        if (acc && feed_q.size() > 0) feed_q.delete(0);
        if (feed_en && feed_q.size() > 0) begin
            pix_valid_tb[cur] = 1'b1;
            pix_data_tb[cur]  = feed_q[0];
        end else begin
            pix_valid_tb[cur] = 1'b0;
        end
    endtask

    task automatic supply(input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] e);
        frame_px[0] = a; frame_px[1] = b; frame_px[2] = c; frame_px[3] = e;
        feed_q.delete();
        feed_q.push_back(a); feed_q.push_back(b);
        feed_q.push_back(c); feed_q.push_back(e);
        feed_en = 1'b1;
        repeat (3) step();
    endtask

    task automatic build_expected();
        int k;
        logic [11:0] w;
        k = 0;
        for (int f = 0; f < c_f; f++) begin
            exp_half[k] = 1'b1; exp_half[k+1] = 1'b0; k += 2;
        end
        for (int l = 0; l < c_nl; l++) begin
            for (int p = 0; p < c_p; p++) begin
                w = {1'b1, frame_px[l*c_p+p], 1'b0};
                for (int b = 11; b >= 0; b--) begin
                    exp_half[k] = w[b]; exp_half[k+1] = ~w[b]; k += 2;
                end
            end
            for (int g = 0; g < 2*c_g; g++) begin
                exp_half[k] = 1'b0; k++;
            end
        end
    endtask

    task automatic run_frame(input int d, input int req_at,
                             output logic err_pre, output logic err_w0);
        int h, len, mism, oe_bad, done_early, after_bad, s;
        logic [11:0] v;
        h = (d == 0) ? 2 : 1;
        len = h * c_nh;
        mism = 0; oe_bad = 0; done_early = 0; after_bad = 0;
        err_pre = 1'bx; err_w0 = 1'bx;
        build_expected();
        frame_req_tb[d] = 1'b1;
        step();
        frame_req_tb[d] = 1'b0;
        check_val($sformatf("err_clear_at_start_d%0d", d), error_out_tb[d], 0);
        for (int i = 0; i < len; i++) begin
            frame_req_tb[d] = (i == req_at);
            step();
            cap[i] = ser_out_tb[d];
            if (ser_oe_tb[d] !== 1'b1 || busy_tb[d] !== 1'b1) oe_bad++;
            if (frame_done_tb[d] !== 1'b0) done_early++;
            if (i == 2*c_f*h - 2) err_pre = error_out_tb[d];
            if (i == 2*c_f*h) err_w0 = error_out_tb[d];
        end
        frame_req_tb[d] = 1'b0;
        step();
        check_val($sformatf("done_pulse_d%0d", d),
                  {frame_done_tb[d], ser_oe_tb[d], busy_tb[d]}, 3'b100);
        for (int i = 0; i < 20; i++) begin
            step();
            if (frame_done_tb[d] !== 1'b0 || busy_tb[d] !== 1'b0 || ser_oe_tb[d] !== 1'b0) after_bad++;
        end
        check_val($sformatf("oe_busy_in_frame_d%0d", d), oe_bad, 0);
        check_val($sformatf("done_early_d%0d", d), done_early, 0);
        check_val($sformatf("idle_after_frame_d%0d", d), after_bad, 0);
        for (int i = 0; i < len; i++) begin
            if (cap[i] !== exp_half[i/h]) mism++;
        end
        check_val($sformatf("stream_mismatch_cycles_d%0d", d), mism, 0);
        for (int w = 0; w < 4; w++) begin
            s = 2*c_f + (w/c_p)*(24*c_p + 2*c_g) + 24*(w%c_p);
            for (int b = 0; b < 12; b++) v[11-b] = cap[(s + 2*b) * h];
            check_val($sformatf("word%0d_d%0d", w, d), v, {1'b1, frame_px[w], 1'b0});
        end
    endtask

    initial begin
        logic ep, e0;
        int   n;
        int   dn;

        RESET_N_tb = 1'b0;
        for (int d = 0; d < 2; d++) begin
            enable_tb[d] = 1'b0; frame_req_tb[d] = 1'b0;
            pix_valid_tb[d] = 1'b0; pix_data_tb[d] = '0;
        end
        #12;
        check_val("reset_outs_d0", outs(0), 6'b0);
        check_val("reset_outs_d1", outs(1), 6'b0);
        RESET_N_tb = 1'b1;
        #1;
        check_val("ready_before_first_edge", pix_ready_tb[0], 0);
        step();
        check_val("ready_after_first_edge", pix_ready_tb[0], 1);
        enable_tb[0] = 1'b1; enable_tb[1] = 1'b1;

        // Fully supplied frame.
        supply(10'h2A5, 10'h15A, 10'h3FF, 10'h000);
        run_frame(0, -1, ep, e0);
        check_val("err_supplied", {ep, e0, error_out_tb[0]}, 3'b000);

        // Starved frame: all payloads zero and sticky underrun.
        feed_q.delete(); feed_en = 1'b0;
        frame_px[0] = '0; frame_px[1] = '0; frame_px[2] = '0; frame_px[3] = '0;
        run_frame(0, -1, ep, e0);
        check_val("err_before_word0", ep, 0);
        check_val("err_after_word0", e0, 1);
        check_val("err_sticky_end", error_out_tb[0], 1);

        // Request pulsed mid-frame is ignored; flag cleared by the new frame.
        supply(10'h001, 10'h200, 10'h155, 10'h0AA);
        run_frame(0, 50, ep, e0);
        check_val("err_after_refill", {e0, error_out_tb[0]}, 2'b00);

        // Abort mid word 1 while the holding register is full.
        supply(10'h123, 10'h321, 10'h3FF, 10'h1C7);
        frame_req_tb[0] = 1'b1; step(); frame_req_tb[0] = 1'b0;
        repeat (77) step();
        check_val("ready_before_abort", pix_ready_tb[0], 0);
        enable_tb[0] = 1'b0; feed_en = 1'b0; pix_valid_tb[0] = 1'b0;
        n = 0;
        while (ser_oe_tb[0] !== 1'b0 && n < 8) begin step(); n++; end
        check_val("abort_oe_latency_le2", (n <= 2), 1);
        check_val("abort_state", {busy_tb[0], pix_ready_tb[0], ser_out_tb[0]}, 3'b010);
        dn = 0;
        for (int i = 0; i < 12; i++) begin step(); if (frame_done_tb[0] !== 1'b0) dn++; end
        check_val("abort_no_done", dn, 0);
        enable_tb[0] = 1'b1;

        // Asynchronous reset in the first gap, then the first frame again.
        supply(10'h2A5, 10'h15A, 10'h3FF, 10'h000);
        frame_req_tb[0] = 1'b1; step(); frame_req_tb[0] = 1'b0;
        repeat (116) step();
        check_val("pre_reset_oe_busy", {ser_oe_tb[0], busy_tb[0], ser_out_tb[0]}, 3'b110);
        #2 RESET_N_tb = 1'b0;
        #1;
        check_val("async_reset_outs", outs(0), 6'b0);
        #10 RESET_N_tb = 1'b1;
        supply(10'h2A5, 10'h15A, 10'h3FF, 10'h000);
        run_frame(0, -1, ep, e0);
        check_val("err_after_reset_frame", error_out_tb[0], 0);

        // One-cycle half-bits.
        cur = 1;
        supply(10'h2A5, 10'h15A, 10'h3FF, 10'h000);
        run_frame(1, -1, ep, e0);
        check_val("err_h1", error_out_tb[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
